// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and default sizes for the MIPS MEM stage.
package mem_access_stage_pkg;
  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles without an ack; expired flags the cycle whose increment would reach TIMEOUT.
module mem_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expired = enable && (count == LAST);
endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: runs loads/stores over a req/ack port, stalls upstream while busy,
// and emits one writeback strobe per retired ALU op or load.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              memory_RD,
  input  logic              memory_WR,
  input  logic              ALU,
  input  logic [ADDR_W-1:0] address_for_memory_RD,
  input  logic [ADDR_W-1:0] address_for_memory_WR,
  input  logic [DATA_W-1:0] data_for_WR,
  input  logic [REG_AW-1:0] address_for_register_RD,
  input  logic [DATA_W-1:0] result,
  output logic              hold,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              timeout_err
);
  state_t state, state_next;
  logic busy, idle_go, start_wr, start_rd, alu_go, expired;
  logic kill, is_load;
  logic [REG_AW-1:0] dest;

  assign busy     = (state == BUSY);
  assign idle_go  = !busy && !flush;
  assign start_wr = idle_go && memory_WR;
  assign start_rd = idle_go && !memory_WR && memory_RD;
  assign alu_go   = idle_go && !memory_WR && !memory_RD && ALU;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!busy),
    .enable  (busy && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    hold       = 1'b0;
    case (state)
      IDLE: if (start_wr || start_rd) begin
        state_next = BUSY;
        hold       = 1'b1;
      end
      BUSY: if (mem_ack || expired) state_next = IDLE;
            else                    hold       = 1'b1;
      default: state_next = IDLE;
    endcase
    if (!reset_n) hold = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      timeout_err <= 1'b0;
      kill        <= 1'b0;
      is_load     <= 1'b0;
      dest        <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (start_wr) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= address_for_memory_WR;
        mem_wdata <= data_for_WR;
        is_load   <= 1'b0;
        kill      <= 1'b0;
      end else if (start_rd) begin
        mem_req <= 1'b1;
        mem_we  <= 1'b0;
        mem_addr <= address_for_memory_RD;
        dest    <= address_for_register_RD;
        is_load <= 1'b1;
        kill    <= 1'b0;
      end else if (alu_go && address_for_register_RD != '0) begin
        wb_valid <= 1'b1;
        wb_addr  <= address_for_register_RD;
        wb_data  <= result;
      end
      if (busy) begin
        // A flush never withdraws the request; it only drops the writeback.
        if (flush) kill <= 1'b1;
        if (mem_ack) begin
          mem_req <= 1'b0;
          kill    <= 1'b0;
          if (is_load && !kill && !flush && dest != '0) begin
            wb_valid <= 1'b1;
            wb_addr  <= dest;
            wb_data  <= mem_rdata;
          end
        end else if (expired) begin
          mem_req     <= 1'b0;
          kill        <= 1'b0;
          timeout_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized op-level bench for mem_access_stage with a transaction-level reference model.
module tb_mem_access_stage;
  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush, memory_RD, memory_WR, ALU;
  logic [10:0] address_for_memory_RD, address_for_memory_WR;
  logic [31:0] data_for_WR, result, mem_rdata;
  logic [4:0]  address_for_register_RD;
  logic        mem_ack;
  logic        hold, mem_req, mem_we, wb_valid, timeout_err;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, wb_data;
  logic [4:0]  wb_addr;

  mem_access_stage #(.ADDR_W(11), .DATA_W(32), .REG_AW(5), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .memory_RD(memory_RD),
    .memory_WR(memory_WR), .ALU(ALU), .address_for_memory_RD(address_for_memory_RD),
    .address_for_memory_WR(address_for_memory_WR), .data_for_WR(data_for_WR),
    .address_for_register_RD(address_for_register_RD), .result(result), .hold(hold),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;
  logic chk_en = 1'b0;

  // Expected values for the current cycle, plus what the current op schedules for the next one.
  logic        exp_hold, exp_req, exp_we, exp_wbv, exp_terr;
  logic [10:0] exp_addr;
  logic [31:0] exp_wdata, exp_wbd;
  logic [4:0]  exp_wba;
  logic        nxt_wbv = 1'b0, nxt_terr = 1'b0;
  logic [31:0] nxt_wbd = '0;
  logic [4:0]  nxt_wba = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("hold", 32'(hold), 32'(exp_hold));
      check("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
      check("wb_valid", 32'(wb_valid), 32'(exp_wbv));
      if (exp_wbv) begin
        check("wb_addr", 32'(wb_addr), 32'(exp_wba));
        check("wb_data", wb_data, exp_wbd);
      end
      check("timeout_err", 32'(timeout_err), 32'(exp_terr));
    end
  end

  // kind: 0 nop, 1 ALU, 2 load, 3 store, 4 store with RD also set.
  // ack_at: cycle of the op (0 = capture cycle) carrying mem_ack; 0 or >TO = never.
  // flush_at: cycle of the op carrying a flush pulse; -1 = none.
  task automatic run_op(input int kind, input logic [10:0] ra, input logic [10:0] wa,
                        input logic [31:0] wd, input logic [31:0] res, input logic [31:0] rdata,
                        input logic [4:0] rg, input int ack_at, input int flush_at);
    bit is_mem = (kind >= 2);
    bit captured = is_mem && (flush_at != 0);
    bit noise = 1'($urandom_range(0, 1));
    int n;
    if (!captured) n = 1;
    else if (ack_at >= 1 && ack_at <= TO) n = ack_at + 1;
    else n = TO + 1;
    for (int c = 0; c < n; c++) begin
      exp_wbv = nxt_wbv; exp_wba = nxt_wba; exp_wbd = nxt_wbd; nxt_wbv = 1'b0;
      exp_terr = nxt_terr;
      flush = (c == flush_at);
      memory_WR = (kind >= 3);
      memory_RD = (kind == 2 || kind == 4);
      ALU = (kind == 1) || (is_mem && noise);
      address_for_memory_RD = ra; address_for_memory_WR = wa;
      data_for_WR = wd; result = res; address_for_register_RD = rg;
      mem_ack = captured && c >= 1 && c == ack_at;
      mem_rdata = mem_ack ? rdata : $urandom();
      exp_hold = captured && (c != n - 1);
      exp_req = captured && c >= 1;
      exp_we = (kind >= 3);
      exp_addr = (kind >= 3) ? wa : ra;
      exp_wdata = wd;
      if (mem_ack && kind == 2 && !(flush_at >= 1 && flush_at <= c) && rg != 0) begin
        nxt_wbv = 1'b1; nxt_wba = rg; nxt_wbd = rdata;
      end
      if (captured && !mem_ack && c == TO) nxt_terr = 1'b1;
      if (kind == 1 && flush_at != 0 && rg != 0) begin
        nxt_wbv = 1'b1; nxt_wba = rg; nxt_wbd = res;
      end
      @(negedge clock);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic nop();
    run_op(0, '0, '0, '0, '0, '0, '0, 0, -1);
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 0; memory_RD = 0; memory_WR = 1; ALU = 0; mem_ack = 0;
    address_for_memory_RD = '0; address_for_memory_WR = 11'h155; data_for_WR = '1;
    result = '0; address_for_register_RD = '0; mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hold", 32'(hold), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_addr", 32'(wb_addr), 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    memory_WR = 0;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk_en = 1'b1;

    run_op(1, '0, '0, '0, 32'h1234, '0, 5'd5, 0, -1);
    check("lit_alu_wbv", 32'(wb_valid), 1);
    check("lit_alu_wbd", wb_data, 32'h1234);
    run_op(2, 11'h010, '0, '0, '0, 32'hCAFEF00D, 5'd3, 4, -1);
    check("lit_ld_wbv", 32'(wb_valid), 1);
    check("lit_ld_wbd", wb_data, 32'hCAFEF00D);
    check("lit_ld_wba", 32'(wb_addr), 3);
    run_op(4, 11'h123, 11'h7FF, 32'hA5A5A5A5, '0, 32'h0BAD0BAD, 5'd9, 2, -1);
    check("lit_st_we", 32'(mem_we), 1);
    check("lit_st_addr", 32'(mem_addr), 32'h7FF);
    check("lit_st_nowb", 32'(wb_valid), 0);
    run_op(2, 11'h020, '0, '0, '0, 32'h1111, 5'd4, 0, -1);
    check("lit_to_err", 32'(timeout_err), 1);
    check("lit_to_req", 32'(mem_req), 0);
    run_op(2, 11'h030, '0, '0, '0, 32'h2222, 5'd6, 3, 2);
    check("lit_flush_nowb", 32'(wb_valid), 0);
    run_op(1, '0, '0, '0, 32'h5555, '0, 5'd0, 0, -1);
    check("lit_r0_nowb", 32'(wb_valid), 0);
    run_op(2, 11'h040, '0, '0, '0, 32'h3333, 5'd8, TO, -1);
    run_op(1, '0, '0, '0, 32'h4444, '0, 5'd2, 0, 0);

    for (int i = 0; i < 150; i++) begin
      int kind = $urandom_range(0, 4);
      int ack_at, flush_at, n;
      if ($urandom_range(0, 9) == 0) ack_at = 0;
      else if ($urandom_range(0, 9) == 0) ack_at = TO;
      else ack_at = $urandom_range(1, 6);
      n = (ack_at == 0) ? TO + 1 : ack_at + 1;
      flush_at = -1;
      if ($urandom_range(0, 5) == 0) flush_at = (kind >= 2) ? $urandom_range(0, n - 1) : 0;
      run_op(kind, 11'($urandom()), 11'($urandom()), $urandom(), $urandom(), $urandom(),
             5'($urandom()), ack_at, flush_at);
    end
    nop();

    // Reset in the middle of a transfer.
    chk_en = 1'b0;
    memory_RD = 1; memory_WR = 0; ALU = 0; flush = 0; mem_ack = 0;
    address_for_memory_RD = 11'h050; address_for_register_RD = 5'd1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("pre_rst_req", 32'(mem_req), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 0);
    check("mid_rst_hold", 32'(hold), 0);
    check("mid_rst_terr", 32'(timeout_err), 0);
    memory_RD = 0;
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    nxt_wbv = 1'b0; nxt_terr = 1'b0;
    chk_en = 1'b1;
    run_op(1, '0, '0, '0, 32'h7777, '0, 5'd7, 0, -1);
    check("post_rst_alu", 32'(wb_valid), 1);
    nop();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
